// File: rtl/gmsk_burst_feeder_pkg.sv
`default_nettype none
// =============================================================================
// Module   : gmsk_burst_feeder_pkg
// Purpose  : Shared constants for the GMSK burst feeder: FSM encodings, GSM
//            burst geometry, fill symbol and PRBS9 seed/step.
// Revision : 1.0
// =============================================================================
package gmsk_burst_feeder_pkg;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_armed = 2'd1;
    localparam logic [1:0] c_st_burst = 2'd2;
    localparam logic [1:0] c_st_guard = 2'd3;

    localparam int c_burst_bits  = 148;
    localparam int c_guard_bits  = 8;
    localparam int c_fifo_aw     = 5;
    localparam int c_prime_level = 16;

    // Fill is a(+1), i.e. a differentially encoded 0.
    localparam logic c_fill_sym = 1'b1;

    localparam logic [8:0] c_prbs9_seed = 9'h1FF;

    // x^9 + x^5 + 1; output bit is the MSB.
    function automatic logic [8:0] prbs9_next(input logic [8:0] s);
        return {s[7:0], s[8] ^ s[4]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gmsk_burst_feeder_bit_fifo.sv
`default_nettype none
// =============================================================================
// Module   : gmsk_burst_feeder_bit_fifo
// Purpose  : 1-bit-wide synchronous FIFO, depth 2**AW, with flush and level.
// Revision : 1.0
// =============================================================================
module gmsk_burst_feeder_bit_fifo #(
    parameter int AW = 5
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          din_i,
    input  logic          flush_i,
    output logic          dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam int          c_depth = 2 ** AW;
    localparam logic [AW:0] c_one   = 1;

    logic          mem_q [c_depth];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          w_push;
    logic          w_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;

    // A simultaneous pop frees the slot being written, and a simultaneous push
    // feeds an empty FIFO straight through, so both are honoured at the edges.
    assign w_push = push_i && (!full_o || pop_i);
    assign w_pop  = pop_i && (!empty_o || push_i);
    assign dout_o = empty_o ? din_i : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + c_one;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + c_one;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/gmsk_burst_feeder.sv
`default_nettype none
// =============================================================================
// Module   : gmsk_burst_feeder
// Purpose  : Buffers burst bits, GSM-differentially encodes them and presents
//            one symbol per modulator strobe, filling idle/guard time with a(+1).
//            Optional PRBS9 data source: define GMSK_FEEDER_PRBS_EN.
// Revision : 1.0
// =============================================================================
module gmsk_burst_feeder
    import gmsk_burst_feeder_pkg::*;
#(
    parameter int BURST_BITS  = c_burst_bits,
    parameter int GUARD_BITS  = c_guard_bits,
    parameter int FIFO_AW     = c_fifo_aw,
    parameter int PRIME_LEVEL = c_prime_level
) (
    input  logic clock,
    input  logic reset_n,
    input  logic bit_i,
    input  logic bit_valid_i,
    output logic bit_ready_o,
    input  logic burst_start_i,
    input  logic symbol_strobe_i,
    output logic current_symbol_o,
    output logic burst_active_o,
    output logic burst_done_o,
    output logic underrun_o
`ifdef GMSK_FEEDER_PRBS_EN
    ,
    input  logic prbs_mode_i
`endif
);

    localparam int               c_lw         = FIFO_AW + 1;
    localparam logic [FIFO_AW:0] c_prime_lvl  = c_lw'(PRIME_LEVEL);
    localparam logic [7:0]       c_last_bit   = 8'(BURST_BITS - 1);
    localparam logic [3:0]       c_last_guard = 4'(GUARD_BITS - 1);

    logic [1:0]       state_q, state_d;
    logic             pending_q, pending_d;
    logic             diff_q, diff_d;
    logic [7:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]       guard_cnt_q, guard_cnt_d;
    logic             sym_q, sym_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;

    logic             w_fifo_push, w_fifo_pop, w_fifo_flush;
    logic             w_fifo_dout, w_fifo_full, w_fifo_empty;
    logic [FIFO_AW:0] w_fifo_level;
    logic             w_data_phase, w_arm, w_take, w_underrun;
    logic             w_primed, w_bit_avail, w_data_bit;

    assign w_data_phase = (state_q == c_st_armed) || (state_q == c_st_burst);
    assign w_arm        = (state_q == c_st_idle) && pending_q && w_primed;
    assign w_take       = w_data_phase && symbol_strobe_i && w_bit_avail;
    assign w_underrun   = w_data_phase && symbol_strobe_i && !w_bit_avail;

`ifdef GMSK_FEEDER_PRBS_EN
    logic       prbs_sel_q;
    logic [8:0] lfsr_q;

    assign w_primed    = prbs_mode_i || (w_fifo_level >= c_prime_lvl);
    assign w_bit_avail = prbs_sel_q || !w_fifo_empty;
    assign w_data_bit  = prbs_sel_q ? lfsr_q[8] : w_fifo_dout;
    assign w_fifo_pop  = w_take && !prbs_sel_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prbs_sel_q <= 1'b0;
            lfsr_q     <= c_prbs9_seed;
        end else if (w_arm) begin
            prbs_sel_q <= prbs_mode_i;
            lfsr_q     <= c_prbs9_seed;
        end else if (w_take) begin
            lfsr_q     <= prbs9_next(lfsr_q);
        end
    end
`else
    assign w_primed    = (w_fifo_level >= c_prime_lvl);
    assign w_bit_avail = !w_fifo_empty;
    assign w_data_bit  = w_fifo_dout;
    assign w_fifo_pop  = w_take;
`endif

    assign w_fifo_flush = w_underrun;
    // A pop in this cycle frees a slot, so a full FIFO may still accept.
    assign bit_ready_o  = !w_fifo_full || w_fifo_pop;
    assign w_fifo_push  = bit_valid_i && bit_ready_o;

    gmsk_burst_feeder_bit_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (w_fifo_push),
        .pop_i   (w_fifo_pop),
        .din_i   (bit_i),
        .flush_i (w_fifo_flush),
        .dout_o  (w_fifo_dout),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .level_o (w_fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        diff_d      = diff_q;
        bit_cnt_d   = bit_cnt_q;
        guard_cnt_d = guard_cnt_q;
        sym_d       = sym_q;
        active_d    = active_q;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        case (state_q)
            c_st_idle: begin
                if (burst_start_i) pending_d = 1'b1;
                if (symbol_strobe_i) begin
                    sym_d    = c_fill_sym;
                    active_d = 1'b0;
                end
                if (w_arm) begin
                    state_d   = c_st_armed;
                    pending_d = 1'b0;
                    diff_d    = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            c_st_armed, c_st_burst: begin
                if (w_take) begin
                    sym_d     = ~(w_data_bit ^ diff_q);
                    diff_d    = w_data_bit;
                    active_d  = 1'b1;
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (bit_cnt_q == c_last_bit) begin
                        state_d     = c_st_guard;
                        guard_cnt_d = '0;
                    end else begin
                        state_d = c_st_burst;
                    end
                end else if (w_underrun) begin
                    sym_d       = c_fill_sym;
                    active_d    = 1'b0;
                    underrun_d  = 1'b1;
                    state_d     = c_st_guard;
                    guard_cnt_d = '0;
                end
            end
            c_st_guard: begin
                if (symbol_strobe_i) begin
                    sym_d    = c_fill_sym;
                    active_d = 1'b0;
                    if (guard_cnt_q == c_last_guard) begin
                        done_d      = 1'b1;
                        state_d     = c_st_idle;
                        guard_cnt_d = '0;
                    end else begin
                        guard_cnt_d = guard_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= c_st_idle;
            pending_q   <= 1'b0;
            diff_q      <= 1'b1;
            bit_cnt_q   <= '0;
            guard_cnt_q <= '0;
            sym_q       <= c_fill_sym;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            diff_q      <= diff_d;
            bit_cnt_q   <= bit_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            sym_q       <= sym_d;
            active_q    <= active_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign current_symbol_o = sym_q;
    assign burst_active_o   = active_q;
    assign burst_done_o     = done_q;
    assign underrun_o       = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_gmsk_burst_feeder.sv
`default_nettype none
// =============================================================================
// Module   : tb_gmsk_burst_feeder
// Purpose  : Directed, table-driven bench for gmsk_burst_feeder (default build).
// Revision : 1.0
// =============================================================================
module tb_gmsk_burst_feeder;

    localparam int BURST = 148;
    localparam int GUARD = 8;

    logic clock = 1'b0;
    logic reset_n, bit_i, bit_valid_i, burst_start_i, symbol_strobe_i;
    logic bit_ready_o, current_symbol_o, burst_active_o, burst_done_o, underrun_o;

    int   checks = 0;
    int   errors = 0;
    int   n_accepted = 0;
    logic push_q [$];
    logic exp_bits [0:199];
    logic obs_sym  [1:200];
    logic obs_act  [1:200];
    logic obs_done [1:200];
    logic obs_und  [1:200];

    typedef struct {
        int   idx;
        logic sym;
        logic act;
        logic done;
        logic und;
    } vec_t;
    vec_t tbl [12];

    always #5 clock = ~clock;

    gmsk_burst_feeder dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .bit_i            (bit_i),
        .bit_valid_i      (bit_valid_i),
        .bit_ready_o      (bit_ready_o),
        .burst_start_i    (burst_start_i),
        .symbol_strobe_i  (symbol_strobe_i),
        .current_symbol_o (current_symbol_o),
        .burst_active_o   (burst_active_o),
        .burst_done_o     (burst_done_o),
        .underrun_o       (underrun_o)
    );

    // Feeds push_q into the DUT whenever it is ready.
    initial begin : p_push
        logic xfer;
        bit_valid_i = 1'b0;
        bit_i       = 1'b0;
        forever begin
            @(negedge clock);
            xfer = bit_valid_i & bit_ready_o & reset_n;
            @(posedge clock);
            #1;
            if (xfer && push_q.size() > 0) begin
                void'(push_q.pop_front());
                n_accepted++;
            end
            if (push_q.size() > 0) begin
                bit_valid_i = 1'b1;
                bit_i       = push_q[0];
            end else begin
                bit_valid_i = 1'b0;
                bit_i       = 1'b0;
            end
        end
    end

    initial begin : p_watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic do_strobe(input int idx, input int gap);
        symbol_strobe_i = 1'b1;
        cyc();
        symbol_strobe_i = 1'b0;
        obs_sym[idx]  = current_symbol_o;
        obs_act[idx]  = burst_active_o;
        obs_done[idx] = burst_done_o;
        obs_und[idx]  = underrun_o;
        repeat (gap - 1) cyc();
    endtask

    task automatic run_strobes(input int n, input int gap);
        for (int s = 1; s <= n; s++) do_strobe(s, gap);
    endtask

    task automatic load_bits(input int n);
        for (int i = 0; i < n; i++) push_q.push_back(exp_bits[i]);
    endtask

    task automatic start_burst();
        repeat (40) cyc();
        burst_start_i = 1'b1;
        cyc();
        burst_start_i = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic verify_burst(input string nm, input int n_data, input bit und_case, input int n_str);
        logic prev;
        logic e;
        int   sym_err, act_err, done_n, done_at, und_n, und_at, guard_end;
        prev = 1'b1;
        sym_err = 0; act_err = 0; done_n = 0; done_at = 0; und_n = 0; und_at = 0;
        guard_end = n_data + (und_case ? 1 : 0) + GUARD;
        for (int s = 1; s <= n_str; s++) begin
            if (s <= n_data) begin
                e    = ~(exp_bits[s-1] ^ prev);
                prev = exp_bits[s-1];
            end else begin
                e = 1'b1;
            end
            if (obs_sym[s] !== e) sym_err++;
            if (obs_act[s] !== (s <= n_data)) act_err++;
            if (obs_done[s] === 1'b1) begin done_n++; done_at = s; end
            if (obs_und[s] === 1'b1) begin und_n++; und_at = s; end
        end
        check({nm, "_sym_errs"}, sym_err, 0);
        check({nm, "_active_errs"}, act_err, 0);
        check({nm, "_done_count"}, done_n, 1);
        check({nm, "_done_strobe"}, done_at, guard_end);
        check({nm, "_underrun_count"}, und_n, und_case ? 1 : 0);
        check({nm, "_underrun_strobe"}, und_at, und_case ? n_data + 1 : 0);
    endtask

    initial begin : p_main
        logic [5:0] pat;
        tbl[0]  = '{1,   1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{2,   1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{3,   1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{4,   1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{5,   1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{6,   1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{7,   1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{148, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{149, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{155, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{156, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{157, 1'b1, 1'b0, 1'b0, 1'b0};

        reset_n = 1'b0;
        burst_start_i = 1'b0;
        symbol_strobe_i = 1'b0;
        repeat (3) cyc();
        #2 reset_n = 1'b1;
        cyc();

        // Reset state and idle fill
        check("rst_symbol", current_symbol_o, 1);
        check("rst_active", burst_active_o, 0);
        check("rst_done", burst_done_o, 0);
        check("rst_underrun", underrun_o, 0);
        check("rst_ready", bit_ready_o, 1);
        check("rst_level", dut.u_fifo.level_o, 0);
        run_strobes(3, 64);
        for (int s = 1; s <= 3; s++) begin
            check($sformatf("idle_symbol%0d", s), obs_sym[s], 1);
            check($sformatf("idle_active%0d", s), obs_act[s], 0);
        end
        check("idle_ready", bit_ready_o, 1);

        // Full burst 1,1,0,1,0,0 then zeros
        pat = 6'b001011;
        for (int i = 0; i < BURST; i++) exp_bits[i] = (i < 6) ? pat[i] : 1'b0;
        load_bits(BURST);
        start_burst();
        run_strobes(BURST + GUARD + 2, 4);
        for (int i = 0; i < 12; i++)
            check($sformatf("t2_vec%0d", tbl[i].idx),
                  {obs_sym[tbl[i].idx], obs_act[tbl[i].idx], obs_done[tbl[i].idx], obs_und[tbl[i].idx]},
                  {tbl[i].sym, tbl[i].act, tbl[i].done, tbl[i].und});
        verify_burst("t2", BURST, 1'b0, BURST + GUARD + 2);

        // Short burst: 20 bits then underrun
        for (int i = 0; i < 20; i++) exp_bits[i] = (((i * 7 + 3) % 5) < 2);
        load_bits(20);
        start_burst();
        run_strobes(20 + 1 + GUARD + 2, 4);
        verify_burst("t3", 20, 1'b1, 20 + 1 + GUARD + 2);
        check("t3_level", dut.u_fifo.level_o, 0);

        // Fill to full, then push and pop in the same cycle at full
        n_accepted = 0;
        for (int i = 0; i < 40; i++) push_q.push_back(1'b1);
        for (int k = 0; k < 100 && bit_ready_o; k++) cyc();
        @(negedge clock);
        check("t4_ready_fall", bit_ready_o, 0);
        check("t4_pushes", n_accepted, 32);
        check("t4_level_full", dut.u_fifo.level_o, 32);
        cyc();
        burst_start_i = 1'b1;
        cyc();
        burst_start_i = 1'b0;
        repeat (3) cyc();
        do_strobe(1, 4);
        check("t4_level_pushpop", dut.u_fifo.level_o, 32);
        check("t4_pushes_pushpop", n_accepted, 33);
        check("t4_first_sym", {obs_sym[1], obs_act[1]}, 2'b11);
        #2 reset_n = 1'b0;
        push_q.delete();
        repeat (3) cyc();
        #2 reset_n = 1'b1;
        cyc();

        // Asynchronous reset at burst symbol 70, then a fresh burst
        for (int i = 0; i < BURST; i++) exp_bits[i] = ((i % 3) == 2);
        load_bits(BURST);
        start_burst();
        run_strobes(70, 4);
        check("t5_pre_reset", {obs_sym[70], obs_act[70]}, 2'b01);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_symbol", current_symbol_o, 1);
        check("t5_rst_active", burst_active_o, 0);
        check("t5_rst_ready", bit_ready_o, 1);
        check("t5_rst_pulses", {burst_done_o, underrun_o}, 0);
        check("t5_rst_level", dut.u_fifo.level_o, 0);
        push_q.delete();
        repeat (3) cyc();
        #2 reset_n = 1'b1;
        cyc();
        for (int i = 0; i < BURST; i++) exp_bits[i] = (((i * 5) % 7) > 3);
        load_bits(BURST);
        start_burst();
        run_strobes(BURST + GUARD + 2, 4);
        check("t5_first_sym", obs_sym[1], 0);
        verify_burst("t5", BURST, 1'b0, BURST + GUARD + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
